// File: rtl/sprite_engine.sv
// sprite_engine: multi-sprite overlay renderer for the VGA test path.
// Shadow attributes are written at any time and copied to the live set at
// the start of each frame. The live set drives a combinational hit test
// against writable bitmap rows. The winning pixel and the sprite-sprite
// collision flags are then registered.
module sprite_engine #(
    parameter int NUM_SPRITES = 4,
    parameter int SPRITE_W    = 8,
    parameter int SPRITE_H    = 16,
    parameter int COORD_W     = 9,
    localparam int IDX_W      = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
    localparam int BM_AW      = $clog2(NUM_SPRITES * SPRITE_H)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   display_on,
    input  logic [COORD_W-1:0]     hpos,
    input  logic [COORD_W-1:0]     vpos,
    input  logic                   vsync,
    input  logic                   attr_we,
    input  logic [IDX_W-1:0]       attr_sprite,
    input  logic [1:0]             attr_sel,
    input  logic [COORD_W-1:0]     attr_wdata,
    input  logic                   bm_we,
    input  logic [BM_AW-1:0]       bm_addr,
    input  logic [SPRITE_W-1:0]    bm_wdata,
    output logic [2:0]             rgb,
    output logic                   sprite_hit,
    output logic [NUM_SPRITES-1:0] collision,
    output logic                   frame_start
);

    localparam int DX_W     = $clog2(SPRITE_W);
    localparam int DY_W     = $clog2(SPRITE_H);
    localparam int BM_DEPTH = NUM_SPRITES * SPRITE_H;

    // ctrl layout: [5]=enable, [4]=vflip, [3]=hflip, [2:0]=colour
    logic [COORD_W-1:0]     shadow_x  [NUM_SPRITES];
    logic [COORD_W-1:0]     shadow_y  [NUM_SPRITES];
    logic [5:0]             shadow_ctrl [NUM_SPRITES];
    logic [COORD_W-1:0]     live_x    [NUM_SPRITES];
    logic [COORD_W-1:0]     live_y    [NUM_SPRITES];
    logic [5:0]             live_ctrl [NUM_SPRITES];
    logic [SPRITE_W-1:0]    bitmap    [BM_DEPTH];

    logic                   vsync_q;
    logic                   boundary;
    logic [NUM_SPRITES-1:0] opaque;
    logic [NUM_SPRITES-1:0] coll_acc;
    logic [NUM_SPRITES-1:0] coll_term;
    logic                   multi_hit;
    logic [2:0]             pix_color;

    assign boundary  = vsync && !vsync_q;
    assign multi_hit = |(opaque & (opaque - NUM_SPRITES'(1)));
    assign coll_term = (display_on && multi_hit) ? opaque : '0;

    // Shadow writes from the host, and the shadow-to-live copy at the frame boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                shadow_x[i]    <= '0;
                shadow_y[i]    <= '0;
                shadow_ctrl[i] <= '0;
                live_x[i]      <= '0;
                live_y[i]      <= '0;
                live_ctrl[i]   <= '0;
            end
        end else begin
            if (boundary) begin
                live_x    <= shadow_x;
                live_y    <= shadow_y;
                live_ctrl <= shadow_ctrl;
            end
            if (attr_we && (int'(attr_sprite) < NUM_SPRITES)) begin
                case (attr_sel)
                    2'd0:    shadow_x[attr_sprite]    <= attr_wdata;
                    2'd1:    shadow_y[attr_sprite]    <= attr_wdata;
                    2'd2:    shadow_ctrl[attr_sprite] <= attr_wdata[5:0];
                    default: ;
                endcase
            end
        end
    end

    // Bitmap RAM is not cleared by reset, but reset still blocks a write in its cycle
    always_ff @(posedge clk) begin
        if (!reset && bm_we && (int'(bm_addr) < BM_DEPTH)) begin
            bitmap[bm_addr] <= bm_wdata;
        end
    end

    // Per-sprite hit test. Offsets wrap modulo 2^COORD_W, so sprites can straddle the edge.
    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
        logic [COORD_W-1:0] dx;
        logic [COORD_W-1:0] dy;
        logic               in_box;
        logic [DY_W-1:0]    row;
        logic [DX_W-1:0]    col;
        logic [BM_AW-1:0]   addr;

        assign dx     = hpos - live_x[g];
        assign dy     = vpos - live_y[g];
        assign in_box = live_ctrl[g][5] && (dx < COORD_W'(SPRITE_W)) && (dy < COORD_W'(SPRITE_H));
        assign row    = live_ctrl[g][4] ? (DY_W'(SPRITE_H - 1) - dy[DY_W-1:0]) : dy[DY_W-1:0];
        assign col    = live_ctrl[g][3] ? dx[DX_W-1:0] : (DX_W'(SPRITE_W - 1) - dx[DX_W-1:0]);
        assign addr   = BM_AW'(g * SPRITE_H) + BM_AW'(row);
        assign opaque[g] = in_box && bitmap[addr][col];
    end

    // Priority select: scanning from the top index down lets sprite 0 win
    always_comb begin
        pix_color = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (opaque[i]) begin
                pix_color = live_ctrl[i][2:0];
            end
        end
    end

    // Registered pixel output, frame pulse and per-frame collision accumulation
    always_ff @(posedge clk) begin
        if (reset) begin
            rgb         <= '0;
            sprite_hit  <= 1'b0;
            collision   <= '0;
            coll_acc    <= '0;
            vsync_q     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            vsync_q     <= vsync;
            frame_start <= boundary;
            rgb         <= display_on ? pix_color : 3'd0;
            sprite_hit  <= display_on && (|opaque);
            if (boundary) begin
                collision <= coll_acc;
                coll_acc  <= coll_term;
            end else begin
                coll_acc  <= coll_acc | coll_term;
            end
        end
    end

endmodule

// File: tb/tb_sprite_engine.sv
// tb_sprite_engine: directed vector tables and hand-written sequences, then a
// randomized run, all checked against a frame-level reference model.
module tb_sprite_engine;

    localparam int NS = 4;
    localparam int SW = 8;
    localparam int SH = 16;
    localparam int CW = 9;

    logic       clk = 1'b0;
    logic       reset;
    logic       display_on;
    logic [8:0] hpos;
    logic [8:0] vpos;
    logic       vsync;
    logic       attr_we;
    logic [1:0] attr_sprite;
    logic [1:0] attr_sel;
    logic [8:0] attr_wdata;
    logic       bm_we;
    logic [5:0] bm_addr;
    logic [7:0] bm_wdata;
    logic [2:0] rgb;
    logic       sprite_hit;
    logic [3:0] collision;
    logic       frame_start;

    sprite_engine #(
        .NUM_SPRITES(NS),
        .SPRITE_W(SW),
        .SPRITE_H(SH),
        .COORD_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .display_on(display_on),
        .hpos(hpos),
        .vpos(vpos),
        .vsync(vsync),
        .attr_we(attr_we),
        .attr_sprite(attr_sprite),
        .attr_sel(attr_sel),
        .attr_wdata(attr_wdata),
        .bm_we(bm_we),
        .bm_addr(bm_addr),
        .bm_wdata(bm_wdata),
        .rgb(rgb),
        .sprite_hit(sprite_hit),
        .collision(collision),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model state: attribute sets, bitmap contents, frame bookkeeping
    logic [8:0] m_sx [NS];
    logic [8:0] m_sy [NS];
    logic [5:0] m_sc [NS];
    logic [8:0] m_lx [NS];
    logic [8:0] m_ly [NS];
    logic [5:0] m_lc [NS];
    logic [7:0] m_bm [NS*SH];
    logic       m_vprev;
    logic [3:0] m_acc;
    logic [3:0] m_coll;
    logic [2:0] exp_rgb;
    logic       exp_hit;
    logic       exp_fs;

    typedef struct {
        int         grp;
        logic [8:0] h;
        logic [8:0] v;
        logic       d;
        logic [2:0] rgb;
        logic       hit;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input int g, input int h, input int v, input int d, input int c, input int hit);
        vec_t e;
        e.grp = g;
        e.h   = 9'(h);
        e.v   = 9'(v);
        e.d   = 1'(d);
        e.rgb = 3'(c);
        e.hit = 1'(hit);
        vecs.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: predict outputs from the model, advance the model, clock the DUT, compare
    task automatic applyStimulus();
        logic [3:0] opq;
        logic [2:0] col;
        bit         found;
        bit         bnd;
        int         dx, dy, r, b;
        opq   = '0;
        col   = '0;
        found = 0;
        for (int i = 0; i < NS; i++) begin
            dx = (int'(hpos) - int'(m_lx[i]) + 512) % 512;
            dy = (int'(vpos) - int'(m_ly[i]) + 512) % 512;
            if (m_lc[i][5] && dx < SW && dy < SH) begin
                r = m_lc[i][4] ? (SH - 1 - dy) : dy;
                b = m_lc[i][3] ? dx : (SW - 1 - dx);
                if (m_bm[i*SH + r][b]) opq[i] = 1'b1;
            end
        end
        for (int i = 0; i < NS; i++) begin
            if (!found && opq[i]) begin
                col   = m_lc[i][2:0];
                found = 1;
            end
        end
        if (reset) begin
            for (int i = 0; i < NS; i++) begin
                m_sx[i] = '0; m_sy[i] = '0; m_sc[i] = '0;
                m_lx[i] = '0; m_ly[i] = '0; m_lc[i] = '0;
            end
            m_vprev = 0; m_acc = '0; m_coll = '0;
            exp_rgb = '0; exp_hit = 0; exp_fs = 0;
        end else begin
            bnd     = vsync && !m_vprev;
            exp_rgb = display_on ? col : 3'd0;
            exp_hit = display_on && found;
            exp_fs  = bnd;
            if (bnd) begin
                m_coll = m_acc;
                m_acc  = '0;
                for (int i = 0; i < NS; i++) begin
                    m_lx[i] = m_sx[i]; m_ly[i] = m_sy[i]; m_lc[i] = m_sc[i];
                end
            end
            if (display_on && $countones(opq) >= 2) m_acc = m_acc | opq;
            m_vprev = vsync;
            if (attr_we && int'(attr_sprite) < NS) begin
                case (attr_sel)
                    2'd0: m_sx[attr_sprite] = attr_wdata;
                    2'd1: m_sy[attr_sprite] = attr_wdata;
                    2'd2: m_sc[attr_sprite] = attr_wdata[5:0];
                    default: ;
                endcase
            end
            if (bm_we) m_bm[bm_addr] = bm_wdata;
        end
        @(posedge clk);
        #1;
        checkOutput("model_rgb", 32'(rgb), 32'(exp_rgb));
        checkOutput("model_hit", 32'(sprite_hit), 32'(exp_hit));
        checkOutput("model_collision", 32'(collision), 32'(m_coll));
        checkOutput("model_frame_start", 32'(frame_start), 32'(exp_fs));
    endtask

    task automatic writeAttr(input int s, input int sel, input int d);
        display_on  = 0;
        attr_we     = 1;
        attr_sprite = 2'(s);
        attr_sel    = 2'(sel);
        attr_wdata  = 9'(d);
        applyStimulus();
        attr_we = 0;
    endtask

    task automatic setSprite(input int s, input int x, input int y, input int c);
        writeAttr(s, 0, x);
        writeAttr(s, 1, y);
        writeAttr(s, 2, c);
    endtask

    task automatic writeBm(input int a, input int d);
        display_on = 0;
        bm_we      = 1;
        bm_addr    = 6'(a);
        bm_wdata   = 8'(d);
        applyStimulus();
        bm_we = 0;
    endtask

    task automatic frameBoundary();
        display_on = 0;
        vsync      = 1;
        applyStimulus();
        checkOutput("frame_start_pulse", 32'(frame_start), 32'd1);
        applyStimulus();
        checkOutput("frame_start_single", 32'(frame_start), 32'd0);
        vsync = 0;
        applyStimulus();
    endtask

    task automatic pixCheck(input string name, input int h, input int v, input int d, input int c, input int hit);
        hpos       = 9'(h);
        vpos       = 9'(v);
        display_on = 1'(d);
        applyStimulus();
        checkOutput({name, "_rgb"}, 32'(rgb), 32'(c));
        checkOutput({name, "_hit"}, 32'(sprite_hit), 32'(hit));
    endtask

    task automatic runTable(input int g);
        foreach (vecs[k]) begin
            if (vecs[k].grp == g) begin
                hpos       = vecs[k].h;
                vpos       = vecs[k].v;
                display_on = vecs[k].d;
                applyStimulus();
                checkOutput($sformatf("tbl%0d_rgb_h%0d_v%0d", g, vecs[k].h, vecs[k].v), 32'(rgb), 32'(vecs[k].rgb));
                checkOutput($sformatf("tbl%0d_hit_h%0d_v%0d", g, vecs[k].h, vecs[k].v), 32'(sprite_hit), 32'(vecs[k].hit));
            end
        end
    endtask

    // Test sequence: vector tables, corner-case sequences, then random traffic
    initial begin
        reset = 1; display_on = 0; hpos = '0; vpos = '0; vsync = 0;
        attr_we = 0; attr_sprite = '0; attr_sel = '0; attr_wdata = '0;
        bm_we = 0; bm_addr = '0; bm_wdata = '0;
        m_vprev = 0; m_acc = '0; m_coll = '0;
        for (int i = 0; i < NS; i++) begin
            m_sx[i] = '0; m_sy[i] = '0; m_sc[i] = '0;
            m_lx[i] = '0; m_ly[i] = '0; m_lc[i] = '0;
        end
        for (int a = 0; a < NS*SH; a++) m_bm[a] = '0;

        // basic sprite 0 at (100,50), colour 3, row 0 = 10000001
        addVec(1, 100, 50, 1, 3, 1); addVec(1, 101, 50, 1, 0, 0); addVec(1, 107, 50, 1, 3, 1);
        addVec(1, 108, 50, 1, 0, 0); addVec(1,  99, 50, 1, 0, 0); addVec(1, 100, 51, 1, 0, 0);
        addVec(1, 100, 50, 0, 0, 0);
        // hflip, row 0 = 11000000
        addVec(2, 106, 50, 1, 3, 1); addVec(2, 107, 50, 1, 3, 1); addVec(2, 105, 50, 1, 0, 0);
        addVec(2, 100, 50, 1, 0, 0); addVec(2, 108, 50, 1, 0, 0);
        // vflip, row 15 = FF, row 0 still 11000000
        addVec(3, 100, 50, 1, 3, 1); addVec(3, 103, 50, 1, 3, 1); addVec(3, 107, 50, 1, 3, 1);
        addVec(3, 108, 50, 1, 0, 0); addVec(3, 100, 51, 1, 0, 0); addVec(3, 100, 65, 1, 3, 1);
        addVec(3, 101, 65, 1, 3, 1); addVec(3, 102, 65, 1, 0, 0);
        // two solid sprites stacked at (200,100), colours 1 and 6
        addVec(4, 200, 100, 1, 1, 1); addVec(4, 207, 100, 1, 1, 1); addVec(4, 200, 115, 1, 1, 1);
        addVec(4, 208, 100, 1, 0, 0); addVec(4, 200, 116, 1, 0, 0);
        // sprite 0 at x=510 wraps onto columns 0..5
        addVec(5, 509, 100, 1, 0, 0); addVec(5, 510, 100, 1, 1, 1); addVec(5, 511, 100, 1, 1, 1);
        addVec(5,   0, 100, 1, 1, 1); addVec(5,   5, 100, 1, 1, 1); addVec(5,   6, 100, 1, 0, 0);
        // overlapping sprites with display off
        addVec(6, 510, 100, 0, 0, 0); addVec(6, 0, 100, 0, 0, 0);

        repeat (3) applyStimulus();
        checkOutput("reset_rgb", 32'(rgb), 32'd0);
        checkOutput("reset_hit", 32'(sprite_hit), 32'd0);
        checkOutput("reset_collision", 32'(collision), 32'd0);
        checkOutput("reset_frame_start", 32'(frame_start), 32'd0);
        reset = 0;

        for (int a = 0; a < NS*SH; a++) writeBm(a, 0);

        display_on = 1;
        for (int v = 0; v < 16; v++) begin
            for (int h = 0; h < 64; h++) begin
                hpos = 9'(h); vpos = 9'(v);
                applyStimulus();
                checkOutput("sweep_rgb", 32'(rgb), 32'd0);
                checkOutput("sweep_hit", 32'(sprite_hit), 32'd0);
            end
        end
        for (int h = 0; h < 512; h++) begin
            hpos = 9'(h); vpos = 9'd255;
            applyStimulus();
            checkOutput("sweep_rgb", 32'(rgb), 32'd0);
        end
        frameBoundary();
        frameBoundary();
        checkOutput("sweep_collision", 32'(collision), 32'd0);

        setSprite(0, 100, 50, 6'b100011);
        writeBm(0, 8'b10000001);
        frameBoundary();
        runTable(1);

        writeAttr(0, 2, 6'b101011);
        writeBm(0, 8'b11000000);
        frameBoundary();
        runTable(2);

        writeAttr(0, 2, 6'b110011);
        writeBm(15, 8'hFF);
        frameBoundary();
        runTable(3);

        for (int a = 0; a < 2*SH; a++) writeBm(a, 8'hFF);
        setSprite(0, 200, 100, 6'b100001);
        setSprite(1, 200, 100, 6'b100110);
        frameBoundary();
        runTable(4);
        checkOutput("coll_not_yet", 32'(collision), 32'd0);
        frameBoundary();
        checkOutput("coll_after_boundary", 32'(collision), 32'b0011);
        writeAttr(1, 0, 300);
        pixCheck("still_overlap", 200, 100, 1, 1, 1);
        checkOutput("coll_sticky", 32'(collision), 32'b0011);
        frameBoundary();
        checkOutput("coll_second_frame", 32'(collision), 32'b0011);
        pixCheck("apart_s0", 200, 100, 1, 1, 1);
        pixCheck("apart_s1", 300, 100, 1, 6, 1);
        frameBoundary();
        checkOutput("coll_cleared", 32'(collision), 32'd0);

        writeAttr(1, 2, 0);
        writeAttr(0, 0, 100);
        frameBoundary();
        pixCheck("x100_on", 100, 100, 1, 1, 1);
        pixCheck("x100_off", 200, 100, 1, 0, 0);
        writeAttr(0, 0, 200);
        pixCheck("midframe_old", 100, 100, 1, 1, 1);
        pixCheck("midframe_new", 200, 100, 1, 0, 0);
        frameBoundary();
        pixCheck("applied_new", 200, 100, 1, 1, 1);
        pixCheck("applied_old", 100, 100, 1, 0, 0);

        display_on = 0; vsync = 1;
        attr_we = 1; attr_sprite = 2'd0; attr_sel = 2'd0; attr_wdata = 9'd50;
        applyStimulus();
        attr_we = 0;
        checkOutput("bndwrite_fs", 32'(frame_start), 32'd1);
        applyStimulus();
        vsync = 0;
        applyStimulus();
        pixCheck("bndwrite_deferred", 200, 100, 1, 1, 1);
        pixCheck("bndwrite_not_yet", 50, 100, 1, 0, 0);
        frameBoundary();
        pixCheck("bndwrite_applied", 50, 100, 1, 1, 1);
        pixCheck("bndwrite_gone", 200, 100, 1, 0, 0);

        writeAttr(0, 0, 510);
        frameBoundary();
        runTable(5);
        setSprite(1, 510, 100, 6'b100110);
        frameBoundary();
        runTable(6);
        frameBoundary();
        checkOutput("dispoff_no_coll", 32'(collision), 32'd0);
        pixCheck("wrap_overlap", 510, 100, 1, 1, 1);
        frameBoundary();
        checkOutput("wrap_coll", 32'(collision), 32'b0011);

        for (int n = 0; n < 3000; n++) begin
            int k;
            k          = int'($urandom_range(0, NS - 1));
            reset      = ($urandom_range(0, 799) == 0);
            display_on = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 31) == 0) vsync = ~vsync;
            if ($urandom_range(0, 7) == 0) begin
                hpos = 9'($urandom);
                vpos = 9'($urandom);
            end else begin
                hpos = 9'(int'(m_lx[k]) + int'($urandom_range(0, 9)) - 1);
                vpos = 9'(int'(m_ly[k]) + int'($urandom_range(0, 17)) - 1);
            end
            attr_we     = ($urandom_range(0, 15) == 0);
            attr_sprite = 2'($urandom_range(0, 3));
            attr_sel    = 2'($urandom_range(0, 3));
            if (attr_sel == 2'd2)
                attr_wdata = 9'({($urandom_range(0, 3) != 0), 5'($urandom)});
            else if ($urandom_range(0, 1) == 0)
                attr_wdata = 9'(100 + int'($urandom_range(0, 12)));
            else
                attr_wdata = 9'($urandom);
            bm_we    = ($urandom_range(0, 15) == 0);
            bm_addr  = 6'($urandom);
            bm_wdata = 8'($urandom | $urandom);
            applyStimulus();
        end
        reset = 0; attr_we = 0; bm_we = 0; vsync = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/sprite_engine.md
Name: sprite_engine

Overview:
- Parametrised multi-sprite renderer for the VGA test path. It replaces single-sprite, ROM-fixed rendering.
- Holds NUM_SPRITES sprites, each with its own writable bitmap rows, position, flip flags and 3-bit colour.
- Attribute writes are double-buffered so each frame renders tear-free.
- Sits between hvsync_generator (hpos/vpos/display_on/vsync) and the RGB pins. It also reports per-frame sprite-sprite collisions to game logic.

Parameters:
- NUM_SPRITES, 4, number of sprites (1..8); index 0 has highest priority.
- SPRITE_W, 8, sprite width in pixels (power of two, 4..16).
- SPRITE_H, 16, sprite height in rows (power of two, 4..32).
- COORD_W, 9, width of hpos/vpos and of sprite coordinates.
- Derived localparams:
  - IDX_W = max(1, clog2(NUM_SPRITES))
  - BM_AW = clog2(NUM_SPRITES*SPRITE_H)

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- display_on  in  1  visible-area flag
- hpos  in  COORD_W  current pixel column
- vpos  in  COORD_W  current pixel row
- vsync  in  1  vertical sync, active high
- attr_we  in  1  attribute write strobe
- attr_sprite  in  IDX_W  target sprite
- attr_sel  in  2  0=x, 1=y, 2=ctrl, 3=ignored
- attr_wdata  in  COORD_W  write data; ctrl = {enable, vflip, hflip, color[2:0]} in bits [5:0]
- bm_we  in  1  bitmap write strobe
- bm_addr  in  BM_AW  sprite*SPRITE_H + row
- bm_wdata  in  SPRITE_W  row bits; MSB = leftmost pixel
- rgb  out  3  {b,g,r} pixel colour
- sprite_hit  out  1  an opaque sprite pixel is being output
- collision  out  NUM_SPRITES  per-sprite collision flags for the previous frame
- frame_start  out  1  one-cycle pulse at each frame boundary

Behaviour:
- One clock (clk); reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset clears: rgb, sprite_hit, collision, frame_start, the collision accumulator, the vsync delay flop, and all shadow and live attributes (so every sprite is disabled). Bitmap RAM is not reset.
- Attribute writes: attr_we writes the shadow register of (attr_sprite, attr_sel) at the clock edge. A write with attr_sel=3 or attr_sprite>=NUM_SPRITES is a no-op.
- Frame boundary = the cycle where vsync=1 and the registered vsync_q=0. On that cycle:
  - live attributes <= shadow attributes;
  - collision <= accumulator;
  - accumulator <= this cycle's collision term (it is not dropped);
  - frame_start=1 on the following cycle only.
- If an attribute write lands on the boundary cycle, live takes the pre-write shadow value. The new value applies at the next boundary.
- Bitmap RAM: NUM_SPRITES*SPRITE_H x SPRITE_W. Writes take effect at the clock edge. A read of the same address in the same cycle returns the old data.
- Per-sprite hit test (combinational, from live attributes), all arithmetic modulo 2^COORD_W:
  - dx = hpos - x, dy = vpos - y.
  - in_box = enable && dx < SPRITE_W && dy < SPRITE_H.
  - Consequence: a sprite placed near 2^COORD_W wraps onto column/row 0.
- Bitmap addressing:
  - row = vflip ? SPRITE_H-1-dy : dy
  - bit index = hflip ? dx : SPRITE_W-1-dx
  - opaque_i = in_box && bitmap[i*SPRITE_H+row][bit index].
- Output stage (registered, latency exactly 1 cycle from hpos/vpos):
  - rgb <= display_on ? color of the lowest-index opaque sprite : 0; rgb <= 0 when no sprite is opaque.
  - sprite_hit <= display_on && |opaque.
- Collision term: when display_on and at least two opaque_i are set, OR the opaque vector into the accumulator. The accumulator is sticky until the next boundary.
- Reset asserted mid-frame takes priority over every write and boundary event in that cycle.

Test Plan:
- Reset, then sweep a full frame -> rgb=0, sprite_hit=0 everywhere; collision=0 after two frame_start pulses.
- Sprite 0: x=100, y=50, ctrl=0b100011; bitmap row 0 = 8'b10000001; after one boundary, hpos=100, vpos=50 -> next cycle rgb=3'b011, sprite_hit=1. hpos=101 -> rgb=0. hpos=107 -> rgb=3'b011. hpos=108 -> rgb=0.
- Same sprite with hflip=1 and row 0 = 8'b11000000 -> pixels at hpos=106 and 107 only. With vflip=1 and row 15 = 8'hFF -> vpos=50 is fully lit.
- Sprites 0 and 1 both fully opaque at the same position, colours 3'b001 and 3'b110 -> rgb=3'b001. collision=0011 only after the following boundary, and 0000 one frame after the sprites are moved apart.
- Write x=200 mid-frame -> rendering stays at the old x until frame_start. A write on the exact boundary cycle is deferred one frame.
- x=510, SPRITE_W=8, COORD_W=9, row all ones -> lit at hpos 510, 511, 0..5. With display_on=0 -> rgb=0, no collision is accumulated.
